bit_unstuffer: RTL and testbench

BIT_UNSTUFFER -- requirements
Module: bit_unstuffer

---
 rtl/bit_unstuffer.sv | 128 ++++++++++++
 tb/tb_bit_unstuffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_unstuffer.sv
// bit_unstuffer: removes stuffed zeros from an NRZI-decoded bit stream and
// assembles the surviving bits into bytes, LSB first.
//
// Ports:
//   clk         - single clock, rising edge
//   RST         - asynchronous active-high reset
//   en          - packet active; 0 returns to IDLE and drops any partial byte
//   decoded_bit - serial data, valid when pulse=1
//   pulse       - one-cycle bit strobe
//   byte_ready  - consumer accepts byte_out on a rising edge
//   byte_out    - last assembled byte
//   byte_valid  - byte_out holds an unconsumed byte
//   stuff_err   - stuffing violation (STUFF_LEN+1 consecutive ones)
//   overrun     - one-cycle pulse when a completed byte is dropped
//
// Configuration macro: UNSTUFF_ERR_STICKY_EN
//   defined   - stuff_err stays high from detection until en=0 or RST
//   undefined - stuff_err is a one-cycle pulse after detection
module bit_unstuffer #(
    parameter int unsigned STUFF_LEN = 6
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       en,
    input  logic       decoded_bit,
    input  logic       pulse,
    input  logic       byte_ready,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       stuff_err,
    output logic       overrun
);

    localparam int unsigned CNT_W = $clog2(STUFF_LEN + 1);
    localparam logic [CNT_W-1:0] STUFF_MAX = CNT_W'(STUFF_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] ones_cnt;
    logic [2:0]       bit_cnt;
    // Only 7 bits are stored: the 8th bit of a byte goes straight to byte_out.
    logic [6:0]       shreg;

    logic       bit_cycle;
    logic       at_limit;
    logic       accept;
    logic       stuffed;
    logic       violation;
    logic       byte_done;
    logic [7:0] new_byte;

    // Bit classification. IDLE with en=1 behaves like RUN so a bit arriving on
    // the entry cycle is taken as bit 0; ones_cnt is always 0 in IDLE, so no
    // violation can be flagged there.
    always_comb begin
        bit_cycle = en && pulse && (state != ERR);
        at_limit  = (ones_cnt == STUFF_MAX);
        accept    = bit_cycle && !at_limit;
        stuffed   = bit_cycle && at_limit && !decoded_bit;
        violation = bit_cycle && at_limit && decoded_bit;
        byte_done = accept && (bit_cnt == 3'd7);
        new_byte  = {decoded_bit, shreg};
    end

    // State machine, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            ones_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            stuff_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;

            if (!en) begin
                state    <= IDLE;
                ones_cnt <= '0;
                bit_cnt  <= '0;
                shreg    <= '0;
            end else begin
                if (violation) begin
                    state <= ERR;
                end else if (state == IDLE) begin
                    state <= RUN;
                end

                if (accept) begin
                    shreg    <= new_byte[7:1];
                    bit_cnt  <= bit_cnt + 3'd1;
                    ones_cnt <= decoded_bit ? (ones_cnt + CNT_W'(1)) : '0;
                end else if (stuffed) begin
                    ones_cnt <= '0;
                end
            end

            // Output holding register: a new byte is dropped only when the old
            // one is still pending and not being consumed on this edge.
            if (byte_done && (!byte_valid || byte_ready)) begin
                byte_out   <= new_byte;
                byte_valid <= 1'b1;
            end else if (byte_done) begin
                overrun <= 1'b1;
            end else if (byte_ready) begin
                byte_valid <= 1'b0;
            end

`ifdef UNSTUFF_ERR_STICKY_EN
            if (!en) begin
                stuff_err <= 1'b0;
            end else if (violation) begin
                stuff_err <= 1'b1;
            end
`else
            stuff_err <= violation;
`endif
        end
    end

endmodule

// File: tb/tb_bit_unstuffer.sv
// tb_bit_unstuffer: table-driven directed vectors, hand-written corner-case
// sequences, and a randomized run against a queue-based reference model.
module tb_bit_unstuffer;

    localparam int unsigned STUFF_LEN = 6;
`ifdef UNSTUFF_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk;
    logic       RST;
    logic       en;
    logic       decoded_bit;
    logic       pulse;
    logic       byte_ready;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       stuff_err;
    logic       overrun;

    int n_chk  = 0;
    int n_fail = 0;

    bit_unstuffer #(.STUFF_LEN(STUFF_LEN)) dut (
        .clk        (clk),
        .RST        (RST),
        .en         (en),
        .decoded_bit(decoded_bit),
        .pulse      (pulse),
        .byte_ready (byte_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .stuff_err  (stuff_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       p;
        logic       b;
        logic       r;
        logic       v;
        logic [7:0] o;
        logic       e;
        logic       ov;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic e, input logic p, input logic b, input logic r,
                       input logic v, input logic [7:0] o);
        vec_t x;
        x.en = e; x.p = p; x.b = b; x.r = r;
        x.v = v; x.o = o; x.e = 1'b0; x.ov = 1'b0;
        tbl.push_back(x);
    endtask

    // Sends the first n bits of val, LSB first, one bit cycle per clock.
    task automatic send_bits(input logic [7:0] val, input int n);
        logic [7:0] v;
        v = val;
        for (int i = 0; i < n; i++) begin
            pulse = 1'b1;
            decoded_bit = v[i];
            tick();
        end
        pulse = 1'b0;
    endtask

    // Reference model state
    int         m_run;
    bit         m_lock;
    bit         m_q[$];
    bit         m_valid;
    logic [7:0] m_out;
    bit         m_err;
    bit         m_ovr;

    task automatic model_reset();
        m_run = 0; m_lock = 0; m_q.delete();
        m_valid = 0; m_out = 8'h00; m_err = 0; m_ovr = 0;
    endtask

    task automatic model_step(input bit e, input bit p, input bit b, input bit r);
        bit         errp;
        bit         done;
        logic [7:0] nb;
        errp = 0; done = 0; nb = 8'h00; m_ovr = 0;
        if (!e) begin
            m_q.delete(); m_run = 0; m_lock = 0;
        end else if (p && !m_lock) begin
            if (m_run == STUFF_LEN) begin
                if (b) begin m_lock = 1; errp = 1; end
                else m_run = 0;
            end else begin
                m_q.push_back(b);
                m_run = b ? m_run + 1 : 0;
                if (m_q.size() == 8) begin
                    int s;
                    s = 0;
                    for (int i = 0; i < 8; i++) s += int'(m_q[i]) * (1 << i);
                    nb = 8'(s);
                    done = 1;
                    m_q.delete();
                end
            end
        end
        if (done) begin
            if (!m_valid || r) begin m_out = nb; m_valid = 1; end
            else m_ovr = 1;
        end else if (r) begin
            m_valid = 0;
        end
        if (STICKY) begin
            if (!e) m_err = 0;
            else if (errp) m_err = 1;
        end else begin
            m_err = errp;
        end
    endtask

    initial begin
        RST = 1'b1; en = 1'b0; decoded_bit = 1'b0; pulse = 1'b0; byte_ready = 1'b0;
        tick();
        chk("reset_valid", 32'(byte_valid), 32'd0);
        chk("reset_out",   32'(byte_out),   32'd0);
        chk("reset_err",   32'(stuff_err),  32'd0);
        chk("reset_ovr",   32'(overrun),    32'd0);
        RST = 1'b0;

        // Table: 8'hA5 with ready=1, then en drop, then FF with a stuffed zero.
        add(0, 0, 0, 1, 0, 8'h00);
        add(1, 0, 0, 1, 0, 8'h00);
        add(1, 1, 1, 1, 0, 8'h00);
        add(1, 1, 0, 1, 0, 8'h00);
        add(1, 1, 1, 1, 0, 8'h00);
        add(1, 1, 0, 1, 0, 8'h00);
        add(1, 1, 0, 1, 0, 8'h00);
        add(1, 1, 1, 1, 0, 8'h00);
        add(1, 1, 0, 1, 0, 8'h00);
        add(1, 1, 1, 1, 1, 8'hA5);
        add(1, 0, 0, 1, 0, 8'hA5);
        add(0, 0, 0, 1, 0, 8'hA5);
        add(1, 0, 0, 1, 0, 8'hA5);
        for (int i = 0; i < 6; i++) add(1, 1, 1, 1, 0, 8'hA5);
        add(1, 1, 0, 1, 0, 8'hA5);
        add(1, 1, 1, 1, 0, 8'hA5);
        add(1, 1, 1, 1, 1, 8'hFF);
        add(1, 0, 0, 1, 0, 8'hFF);

        for (int i = 0; i < tbl.size(); i++) begin
            en = tbl[i].en; pulse = tbl[i].p; decoded_bit = tbl[i].b; byte_ready = tbl[i].r;
            tick();
            chk($sformatf("tbl%0d_valid", i), 32'(byte_valid), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_out", i),   32'(byte_out),   32'(tbl[i].o));
            chk($sformatf("tbl%0d_err", i),   32'(stuff_err),  32'(tbl[i].e));
            chk($sformatf("tbl%0d_ovr", i),   32'(overrun),    32'(tbl[i].ov));
        end
        chk("ones_cnt_after_ff", 32'(dut.ones_cnt), 32'd2);

        // Stuffing violation: seven ones lock the block until en toggles.
        en = 1'b0; pulse = 1'b0; tick();
        en = 1'b1; tick();
        send_bits(8'hFF, 6);
        chk("pre_violation_err", 32'(stuff_err), 32'd0);
        send_bits(8'h01, 1);
        chk("violation_err", 32'(stuff_err), 32'd1);
        chk("violation_valid", 32'(byte_valid), 32'd0);
        tick();
        chk("err_after_1cyc", 32'(stuff_err), STICKY ? 32'd1 : 32'd0);
        for (int i = 0; i < 16; i++) begin
            pulse = 1'b1; decoded_bit = (i % 3) != 0;
            tick();
            chk("err_lock_valid", 32'(byte_valid), 32'd0);
            chk("err_lock_err",   32'(stuff_err),  STICKY ? 32'd1 : 32'd0);
        end
        pulse = 1'b0; en = 1'b0; tick();
        chk("err_clear_en0", 32'(stuff_err), 32'd0);
        en = 1'b1; tick();
        send_bits(8'h3C, 8);
        chk("recover_valid", 32'(byte_valid), 32'd1);
        chk("recover_out",   32'(byte_out),   32'h3C);
        tick();
        chk("recover_consumed", 32'(byte_valid), 32'd0);

        // Overrun: second byte dropped while first one is pending.
        byte_ready = 1'b0;
        send_bits(8'h11, 8);
        chk("ovr_first_valid", 32'(byte_valid), 32'd1);
        chk("ovr_first_out",   32'(byte_out),   32'h11);
        send_bits(8'h22, 7);
        chk("ovr_mid_ovr", 32'(overrun), 32'd0);
        send_bits(8'h04, 1);
        chk("ovr_pulse",     32'(overrun),    32'd1);
        chk("ovr_keep_out",  32'(byte_out),   32'h11);
        chk("ovr_keep_valid", 32'(byte_valid), 32'd1);
        tick();
        chk("ovr_one_cycle", 32'(overrun), 32'd0);
        byte_ready = 1'b1; tick();
        chk("ready_clears", 32'(byte_valid), 32'd0);
        chk("ready_out_kept", 32'(byte_out), 32'h11);

        // Asynchronous reset mid-byte.
        send_bits(8'h0D, 4);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_out",   32'(byte_out),   32'd0);
        chk("async_rst_valid", 32'(byte_valid), 32'd0);
        chk("async_rst_err",   32'(stuff_err),  32'd0);
        chk("async_rst_ovr",   32'(overrun),    32'd0);
        #1 RST = 1'b0;
        send_bits(8'h5A, 8);
        chk("post_rst_valid", 32'(byte_valid), 32'd1);
        chk("post_rst_out",   32'(byte_out),   32'h5A);

        // Randomized run against the reference model.
        tick();
        RST = 1'b1; #1; RST = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            en          = ($urandom_range(0, 49) != 0);
            pulse       = ($urandom_range(0, 1) != 0);
            decoded_bit = ($urandom_range(0, 9) < 7);
            byte_ready  = ($urandom_range(0, 9) < 3);
            model_step(en, pulse, decoded_bit, byte_ready);
            tick();
            chk("rnd_valid", 32'(byte_valid), 32'(m_valid));
            chk("rnd_out",   32'(byte_out),   32'(m_out));
            chk("rnd_err",   32'(stuff_err),  32'(m_err));
            chk("rnd_ovr",   32'(overrun),    32'(m_ovr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
